alu_op_sequencer: RTL and testbench

- Multicycle sequencer that drives the shared datapath ALU to build multi-step operations from its single-cycle primitives.
- Supported operations: shift by N, multiply by a small count, and two's-complement negate.
- Sits between the multicycle control unit and the ALU. It owns the ALU operand and select lines only while busy; the control unit keeps ALU ownership otherwise.

---
 rtl/alu_op_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Multicycle sequencer that builds shift-by-n, multiply-by-n and negate from single-cycle ALU primitives.
// Optional abort input is compiled in when ALU_OP_SEQUENCER_ABORT_EN is defined.
module alu_op_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
`ifdef ALU_OP_SEQUENCER_ABORT_EN
    input  logic             abort,
`endif
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [CNT_W-1:0] n,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_zero,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam logic [1:0] OP_SHL = 2'b00;
    localparam logic [1:0] OP_SHR = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_NEG = 2'b11;

    localparam logic [2:0] SEL_ADD  = 3'b000;
    localparam logic [2:0] SEL_NOT  = 3'b100;
    localparam logic [2:0] SEL_SHL1 = 3'b101;
    localparam logic [2:0] SEL_SHR1 = 3'b110;
    localparam logic [2:0] SEL_ZERO = 3'b111;

    state_t             state_r;
    logic [1:0]         op_r;
    logic [WIDTH-1:0]   opa_r;
    logic [WIDTH-1:0]   acc_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               busy_r;
    logic               done_r;
    logic [WIDTH-1:0]   result_r;
    logic               zero_r;

    logic               abort_s;
    logic [CNT_W-1:0]   steps_s;
    logic [WIDTH-1:0]   init_s;
    logic [WIDTH-1:0]   alu_a_s;
    logic [WIDTH-1:0]   alu_b_s;
    logic [2:0]         alu_sel_s;

`ifdef ALU_OP_SEQUENCER_ABORT_EN
    assign abort_s = abort;
`else
    assign abort_s = 1'b0;
`endif

    // Step count and accumulator seed for a request presented this cycle; NEG is always not-then-increment.
    always_comb begin
        steps_s = n;
        init_s  = opa;
        case (op)
            OP_SHL, OP_SHR: begin
                steps_s = n;
                init_s  = opa;
            end
            OP_MUL: begin
                steps_s = n;
                init_s  = {WIDTH{1'b0}};
            end
            OP_NEG: begin
                steps_s = CNT_W'(2);
                init_s  = opa;
            end
            default: begin
                steps_s = n;
                init_s  = opa;
            end
        endcase
    end

    // Sequencer state, accumulator, step counter and registered status/result outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            op_r     <= 2'b00;
            opa_r    <= {WIDTH{1'b0}};
            acc_r    <= {WIDTH{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= {WIDTH{1'b0}};
            zero_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (abort_s) begin
                        // Abandon the operation; the previous result stays visible.
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b0;
                    end else begin
                        acc_r <= alu_y;
                        cnt_r <= cnt_r - CNT_W'(1);
                        if (cnt_r == CNT_W'(1)) begin
                            result_r <= alu_y;
                            zero_r   <= alu_zero;
                            state_r  <= ST_DONE;
                            busy_r   <= 1'b0;
                            done_r   <= 1'b1;
                        end else begin
                            state_r  <= ST_RUN;
                            busy_r   <= 1'b1;
                            done_r   <= 1'b0;
                        end
                    end
                end
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        op_r  <= op;
                        opa_r <= opa;
                        acc_r <= init_s;
                        cnt_r <= steps_s;
                        if (steps_s == {CNT_W{1'b0}}) begin
                            // Nothing to iterate: the seed value is already the answer.
                            result_r <= init_s;
                            zero_r   <= (init_s == {WIDTH{1'b0}});
                            state_r  <= ST_DONE;
                            busy_r   <= 1'b0;
                            done_r   <= 1'b1;
                        end else begin
                            state_r  <= ST_RUN;
                            busy_r   <= 1'b1;
                            done_r   <= 1'b0;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    // ALU drive decoded from registered state only; the ALU is parked on "zero" outside RUN.
    always_comb begin
        alu_a_s   = {WIDTH{1'b0}};
        alu_b_s   = {WIDTH{1'b0}};
        alu_sel_s = SEL_ZERO;
        if (state_r == ST_RUN) begin
            alu_a_s = acc_r;
            case (op_r)
                OP_SHL: alu_sel_s = SEL_SHL1;
                OP_SHR: alu_sel_s = SEL_SHR1;
                OP_MUL: begin
                    alu_b_s   = opa_r;
                    alu_sel_s = SEL_ADD;
                end
                OP_NEG: begin
                    if (cnt_r == CNT_W'(2)) begin
                        alu_sel_s = SEL_NOT;
                    end else begin
                        alu_b_s   = WIDTH'(1);
                        alu_sel_s = SEL_ADD;
                    end
                end
                default: alu_sel_s = SEL_ZERO;
            endcase
        end else begin
            alu_a_s   = {WIDTH{1'b0}};
            alu_b_s   = {WIDTH{1'b0}};
            alu_sel_s = SEL_ZERO;
        end
    end

    assign alu_a   = alu_a_s;
    assign alu_b   = alu_b_s;
    assign alu_sel = alu_sel_s;
    assign busy    = busy_r;
    assign done    = done_r;
    assign result  = result_r;
    assign zero    = zero_r;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a behavioural ALU; abort test compiled with ALU_OP_SEQUENCER_ABORT_EN.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] opa;
    logic [4:0]  n;
    logic [31:0] alu_a, alu_b, alu_y, result;
    logic [2:0]  alu_sel;
    logic        alu_zero, busy, done, zero;
`ifdef ALU_OP_SEQUENCER_ABORT_EN
    logic        abort;
`endif

    int checks = 0;
    int errors = 0;
    logic [32:0] sb[$];
    logic [31:0] last_res;

    always #5 clk = ~clk;

    // Reference ALU
    always_comb begin
        case (alu_sel)
            3'b000:  alu_y = alu_a + alu_b;
            3'b100:  alu_y = ~alu_a;
            3'b101:  alu_y = alu_a << 1;
            3'b110:  alu_y = alu_a >> 1;
            default: alu_y = 32'h0;
        endcase
    end
    assign alu_zero = (alu_y == 32'h0);

    alu_op_sequencer #(.WIDTH(32), .CNT_W(5)) dut (
        .clk(clk),
        .reset(reset),
`ifdef ALU_OP_SEQUENCER_ABORT_EN
        .abort(abort),
`endif
        .start(start),
        .op(op),
        .opa(opa),
        .n(n),
        .alu_a(alu_a),
        .alu_b(alu_b),
        .alu_sel(alu_sel),
        .alu_y(alu_y),
        .alu_zero(alu_zero),
        .busy(busy),
        .done(done),
        .result(result),
        .zero(zero)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pulse at %0t", $time);
            end else begin
                logic [32:0] e;
                e = sb.pop_front();
                chk("result", 64'(result), 64'(e[31:0]));
                chk("zero", 64'(zero), 64'(e[32]));
            end
        end
    end

    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [4:0] nn,
                         input logic [31:0] er, input logic ez, input bit chain, input bit poke);
        int steps, cyc;
        bit seen;
        logic [2:0]  es;
        logic [31:0] eb;
        if (!chain) @(negedge clk);
        start = 1'b1; op = o; opa = a; n = nn;
        sb.push_back({ez, er});
        last_res = er;
        @(posedge clk);
        #1 start = 1'b0;
        steps = (o == 2'b11) ? 2 : int'(nn);
        cyc = 0;
        seen = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done === 1'b1) begin
                seen = 1'b1;
            end else if (busy === 1'b1) begin
                case (o)
                    2'b00: begin es = 3'b101; eb = 32'h0; end
                    2'b01: begin es = 3'b110; eb = 32'h0; end
                    2'b10: begin es = 3'b000; eb = a;     end
                    default: begin
                        es = (cyc == 0) ? 3'b100 : 3'b000;
                        eb = (cyc == 0) ? 32'h0 : 32'h1;
                    end
                endcase
                chk("alu_sel", 64'(alu_sel), 64'(es));
                chk("alu_b", 64'(alu_b), 64'(eb));
                if (poke && cyc == 1) begin
                    start = 1'b1; op = 2'b10; opa = 32'h0; n = 5'd1;
                end
                cyc++;
            end
        end
        start = 1'b0;
        chk("done_seen", 64'(seen), 64'd1);
        chk("busy_cycles", 64'(cyc), 64'(steps));
    endtask

    // Start a 4-step SHL and interrupt it during its second step.
    task automatic interrupt_shl(input bit use_abort);
        @(negedge clk);
        start = 1'b1; op = 2'b00; opa = 32'h3; n = 5'd4;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("busy_before_interrupt", 64'(busy), 64'd1);
        if (use_abort) begin
`ifdef ALU_OP_SEQUENCER_ABORT_EN
            abort = 1'b1;
`endif
        end else begin
            reset = 1'b1;
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
`ifdef ALU_OP_SEQUENCER_ABORT_EN
        abort = 1'b0;
`endif
        @(negedge clk);
        chk("busy_after_interrupt", 64'(busy), 64'd0);
        chk("done_after_interrupt", 64'(done), 64'd0);
        chk("sel_after_interrupt", 64'(alu_sel), 64'd7);
        repeat (5) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 2'b00; opa = 32'h0; n = 5'd0;
`ifdef ALU_OP_SEQUENCER_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_zero", 64'(zero), 64'd0);
        chk("rst_sel", 64'(alu_sel), 64'd7);
        chk("rst_alu_a", 64'(alu_a), 64'd0);
        chk("rst_alu_b", 64'(alu_b), 64'd0);

        do_op(2'b00, 32'h0000_0003, 5'd4,  32'h0000_0030, 1'b0, 1'b0, 1'b0);
        do_op(2'b10, 32'd7,         5'd5,  32'd35,        1'b0, 1'b0, 1'b0);
        do_op(2'b10, 32'd7,         5'd0,  32'd0,         1'b1, 1'b0, 1'b0);
        do_op(2'b11, 32'h0000_0001, 5'd9,  32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        do_op(2'b11, 32'h0000_0000, 5'd0,  32'h0,         1'b1, 1'b0, 1'b0);
        do_op(2'b00, 32'h0000_1234, 5'd0,  32'h0000_1234, 1'b0, 1'b0, 1'b0);
        do_op(2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
        do_op(2'b00, 32'h0000_0005, 5'd1,  32'h0000_000A, 1'b0, 1'b1, 1'b0);
        do_op(2'b10, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFD, 1'b0, 1'b1, 1'b0);

        interrupt_shl(1'b0);
        chk("result_after_reset", 64'(result), 64'd0);
        chk("zero_after_reset", 64'(zero), 64'd0);

`ifdef ALU_OP_SEQUENCER_ABORT_EN
        do_op(2'b00, 32'h0000_0001, 5'd2, 32'h0000_0004, 1'b0, 1'b0, 1'b0);
        interrupt_shl(1'b1);
        chk("result_after_abort", 64'(result), 64'(last_res));
        chk("zero_after_abort", 64'(zero), 64'd0);
`endif

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
